// File: rtl/game_pkg.sv
// Shared types and defaults for the plane-war collision/game-state controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int LIVES_W = 3;
  localparam int BOMBS_W = 3;

  localparam int N_ENEMY_DEF       = 4;
  localparam int SCORE_W_DEF       = 16;
  localparam int LIVES_INIT_DEF    = 3;
  localparam int BOMBS_INIT_DEF    = 2;
  localparam int INVINC_FRAMES_DEF = 60;

endpackage

// File: rtl/game_collide_ctrl_if.sv
// Pixel-side sprite alphas, player controls and game-state outputs of the controller.
interface game_collide_ctrl_if #(
  parameter int N_ENEMY = 4,
  parameter int SCORE_W = 16
);
  import game_pkg::*;

  logic                pixel_valid_i;
  logic                frame_start_i;
  logic                me_alpha_i;
  logic                bullet_alpha_i;
  logic [N_ENEMY-1:0]  enemy_alpha_i;
  logic [N_ENEMY-1:0]  enemy_active_i;
  logic                start_i;
  logic                bomb_req_i;
  logic [1:0]          state_o;
  logic [N_ENEMY-1:0]  enemy_hit_o;
  logic                me_crash_o;
  logic                bomb_o;
  logic [SCORE_W-1:0]  score_o;
  logic [LIVES_W-1:0]  lives_o;
  logic [BOMBS_W-1:0]  bombs_o;
  logic                invinc_o;

  modport master (
    output pixel_valid_i, frame_start_i, me_alpha_i, bullet_alpha_i,
           enemy_alpha_i, enemy_active_i, start_i, bomb_req_i,
    input  state_o, enemy_hit_o, me_crash_o, bomb_o, score_o, lives_o,
           bombs_o, invinc_o
  );

  modport slave (
    input  pixel_valid_i, frame_start_i, me_alpha_i, bullet_alpha_i,
           enemy_alpha_i, enemy_active_i, start_i, bomb_req_i,
    output state_o, enemy_hit_o, me_crash_o, bomb_o, score_o, lives_o,
           bombs_o, invinc_o
  );

endinterface

// File: rtl/collide_accum.sv
// Per-channel sticky overlap flags for one frame; presents the committed hit vector and its popcount.
module collide_accum #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [N-1:0]     overlap,
  input  logic [N-1:0]     active,
  input  logic             force_all,
  input  logic             clear,
  output logic [N-1:0]     hit_vec,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [N-1:0] flags;
  logic [N-1:0] live;

  assign live = sample_en ? overlap : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       flags <= '0;
    else if (clear) flags <= '0;
    else            flags <= flags | live;
  end

  // The current pixel is folded in so a pixel coinciding with the clear still counts.
  assign hit_vec = (flags | live | {N{force_all}}) & active;

  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < N; i++)
      hit_cnt = hit_cnt + CNT_W'(hit_vec[i]);
  end

endmodule

// File: rtl/game_collide_ctrl.sv
// Frame-based collision commit, score/lives/bomb bookkeeping and IDLE/PLAY/OVER game FSM.
module game_collide_ctrl
  import game_pkg::*;
#(
  parameter int N_ENEMY       = N_ENEMY_DEF,
  parameter int SCORE_W       = SCORE_W_DEF,
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int BOMBS_INIT    = BOMBS_INIT_DEF,
  parameter int INVINC_FRAMES = INVINC_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  game_collide_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(N_ENEMY + 1);
  localparam int INV_W = $clog2(INVINC_FRAMES + 1);
  localparam int SUM_W = SCORE_W + CNT_W;

  state_t               state_q, state_d;
  logic                 do_start;
  logic                 play, sample_en, commit, bomb_fire;
  logic                 crash_now, crash_take;
  logic                 crash_flag, bomb_pending, bomb_req_q;
  logic [N_ENEMY-1:0]   hit_vec, enemy_hit_q;
  logic [CNT_W-1:0]     hit_cnt;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_q, score_sat;
  logic [LIVES_W-1:0]   lives_q;
  logic [BOMBS_W-1:0]   bombs_q;
  logic [INV_W-1:0]     invinc_q;
  logic                 me_crash_q, bomb_q;

  assign play       = (state_q == ST_PLAY);
  assign sample_en  = play & bus.pixel_valid_i;
  assign commit     = play & bus.frame_start_i;
  assign bomb_fire  = play & bus.bomb_req_i & ~bomb_req_q & (bombs_q != '0);
  assign crash_now  = crash_flag |
                      (sample_en & bus.me_alpha_i & |(bus.enemy_alpha_i & bus.enemy_active_i));
  assign crash_take = commit & crash_now & (invinc_q == '0);

  collide_accum #(
    .N     (N_ENEMY),
    .CNT_W (CNT_W)
  ) u_kill (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en & bus.bullet_alpha_i),
    .overlap   (bus.enemy_alpha_i),
    .active    (bus.enemy_active_i),
    .force_all (bomb_pending),
    .clear     (commit | do_start),
    .hit_vec   (hit_vec),
    .hit_cnt   (hit_cnt)
  );

  assign score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
  assign score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start_i) begin
          state_d  = ST_PLAY;
          do_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (crash_take && lives_q == LIVES_W'(1)) state_d = ST_OVER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q      <= '0;
      lives_q      <= '0;
      bombs_q      <= '0;
      invinc_q     <= '0;
      crash_flag   <= 1'b0;
      bomb_pending <= 1'b0;
      bomb_req_q   <= 1'b0;
      enemy_hit_q  <= '0;
      me_crash_q   <= 1'b0;
      bomb_q       <= 1'b0;
    end else begin
      enemy_hit_q <= '0;
      me_crash_q  <= 1'b0;
      bomb_q      <= 1'b0;
      bomb_req_q  <= bus.bomb_req_i;
      if (do_start) begin
        score_q      <= '0;
        lives_q      <= LIVES_W'(LIVES_INIT);
        bombs_q      <= BOMBS_W'(BOMBS_INIT);
        invinc_q     <= '0;
        crash_flag   <= 1'b0;
        bomb_pending <= 1'b0;
      end else if (play) begin
        if (commit) begin
          enemy_hit_q <= hit_vec;
          score_q     <= score_sat;
          crash_flag  <= 1'b0;
          if (crash_take) begin
            me_crash_q <= 1'b1;
            lives_q    <= lives_q - LIVES_W'(1);
            invinc_q   <= INV_W'(INVINC_FRAMES);
          end else if (invinc_q != '0) begin
            invinc_q <= invinc_q - INV_W'(1);
          end
        end else begin
          crash_flag <= crash_now;
        end
        // A bomb fired on the commit cycle arms the following frame, not this one.
        if (bomb_fire) begin
          bomb_q       <= 1'b1;
          bombs_q      <= bombs_q - BOMBS_W'(1);
          bomb_pending <= 1'b1;
        end else if (commit) begin
          bomb_pending <= 1'b0;
        end
      end
    end
  end

  assign bus.state_o     = state_q;
  assign bus.enemy_hit_o = enemy_hit_q;
  assign bus.me_crash_o  = me_crash_q;
  assign bus.bomb_o      = bomb_q;
  assign bus.score_o     = score_q;
  assign bus.lives_o     = lives_q;
  assign bus.bombs_o     = bombs_q;
  assign bus.invinc_o    = (invinc_q != '0);

endmodule

// File: tb/tb_game_collide_ctrl.sv
// Self-checking bench: frame commits predicted by a small game model and checked through a scoreboard queue.
module tb_game_collide_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_collide_ctrl_if #(.N_ENEMY(4), .SCORE_W(16)) bus ();
  game_collide_ctrl_if #(.N_ENEMY(4), .SCORE_W(4))  sbus ();

  game_collide_ctrl #(.N_ENEMY(4), .SCORE_W(16), .LIVES_INIT(3), .BOMBS_INIT(2),
                      .INVINC_FRAMES(60)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  game_collide_ctrl #(.N_ENEMY(4), .SCORE_W(4), .LIVES_INIT(3), .BOMBS_INIT(2),
                      .INVINC_FRAMES(60)) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    logic [3:0]  hit;
    logic        crash;
    logic        bomb;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [2:0]  bombs;
    logic [1:0]  state;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [3:0] act;
  logic [3:0] m_kill;
  bit         m_crash, m_pend;
  int         m_score, m_lives, m_bombs, m_inv;
  logic [1:0] m_state;

  assign bus.enemy_active_i = act;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pixel_valid_i  = 1'b0;
    bus.frame_start_i  = 1'b0;
    bus.me_alpha_i     = 1'b0;
    bus.bullet_alpha_i = 1'b0;
    bus.enemy_alpha_i  = '0;
    bus.start_i        = 1'b0;
    bus.bomb_req_i     = 1'b0;
  endtask

  task automatic model_pixel(input bit pv, input bit me, input bit bul, input logic [3:0] en);
    if (pv && m_state == 2'd1) begin
      if (bul) m_kill = m_kill | en;
      if (me && |(en & act)) m_crash = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_kill = '0; m_crash = 0; m_pend = 0;
    m_score = 0; m_lives = 0; m_bombs = 0; m_inv = 0; m_state = 2'd0;
  endtask

  task automatic pixels(input bit pv, input bit me, input bit bul, input logic [3:0] en, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pixel_valid_i = pv; bus.me_alpha_i = me; bus.bullet_alpha_i = bul; bus.enemy_alpha_i = en;
      model_pixel(pv, me, bul, en);
      tick();
    end
    clear_inputs();
  endtask

  // Drives the frame_start cycle (optionally with a pixel and a bomb edge), predicts, then checks.
  task automatic close_frame(input string name, input bit pv, input bit me, input bit bul,
                             input logic [3:0] en, input bit bomb_edge);
    exp_t e;
    exp_t g;
    bit   was_play;
    bus.pixel_valid_i = pv; bus.me_alpha_i = me; bus.bullet_alpha_i = bul; bus.enemy_alpha_i = en;
    bus.frame_start_i = 1'b1;
    bus.bomb_req_i    = bomb_edge;
    model_pixel(pv, me, bul, en);
    e.hit = '0; e.crash = 0; e.bomb = 0;
    was_play = (m_state == 2'd1);
    if (was_play) begin
      e.hit = (m_kill | {4{m_pend}}) & act;
      m_score = m_score + $countones(e.hit);
      if (m_score > 65535) m_score = 65535;
      if (m_crash && m_inv == 0) begin
        e.crash = 1; m_lives = m_lives - 1; m_inv = 60;
      end else if (m_inv > 0) begin
        m_inv = m_inv - 1;
      end
      if (m_lives == 0) m_state = 2'd2;
      m_pend = 0;
      if (bomb_edge && m_bombs > 0) begin
        m_bombs = m_bombs - 1; m_pend = 1; e.bomb = 1;
      end
    end
    m_kill = '0; m_crash = 0;
    e.score = 16'(m_score); e.lives = 3'(m_lives); e.bombs = 3'(m_bombs);
    e.state = m_state; e.inv = (m_inv != 0);
    sb.push_back(e);
    tick();
    clear_inputs();
    g = sb.pop_front();
    checks++; if (bus.enemy_hit_o !== g.hit) begin errors++; $display("FAIL %s enemy_hit got %b exp %b", name, bus.enemy_hit_o, g.hit); end
    checks++; if (bus.me_crash_o !== g.crash) begin errors++; $display("FAIL %s me_crash got %b exp %b", name, bus.me_crash_o, g.crash); end
    checks++; if (bus.bomb_o !== g.bomb) begin errors++; $display("FAIL %s bomb got %b exp %b", name, bus.bomb_o, g.bomb); end
    checks++; if (bus.score_o !== g.score) begin errors++; $display("FAIL %s score got %0d exp %0d", name, bus.score_o, g.score); end
    checks++; if (bus.lives_o !== g.lives) begin errors++; $display("FAIL %s lives got %0d exp %0d", name, bus.lives_o, g.lives); end
    checks++; if (bus.bombs_o !== g.bombs) begin errors++; $display("FAIL %s bombs got %0d exp %0d", name, bus.bombs_o, g.bombs); end
    checks++; if (bus.state_o !== g.state) begin errors++; $display("FAIL %s state got %0d exp %0d", name, bus.state_o, g.state); end
    checks++; if (bus.invinc_o !== g.inv) begin errors++; $display("FAIL %s invinc got %b exp %b", name, bus.invinc_o, g.inv); end
    tick();
    checks++;
    if ({bus.enemy_hit_o, bus.me_crash_o, bus.bomb_o} !== 6'b0) begin
      errors++;
      $display("FAIL %s pulse_len got %b exp 000000", name, {bus.enemy_hit_o, bus.me_crash_o, bus.bomb_o});
    end
  endtask

  task automatic start_game(input string name);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    m_state = 2'd1; m_lives = 3; m_bombs = 2; m_score = 0; m_inv = 0;
    m_kill = '0; m_crash = 0; m_pend = 0;
    checks++;
    if ({bus.state_o, bus.lives_o, bus.bombs_o, bus.score_o, bus.invinc_o} !== {2'd1, 3'd3, 3'd2, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL %s state/lives/bombs/score/inv got %0d/%0d/%0d/%0d/%b exp 1/3/2/0/0",
               name, bus.state_o, bus.lives_o, bus.bombs_o, bus.score_o, bus.invinc_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.state_o, bus.score_o, bus.lives_o, bus.bombs_o, bus.invinc_o} !== '0) begin
      errors++;
      $display("FAIL reset state/score/lives/bombs/inv got %0d/%0d/%0d/%0d/%b exp 0/0/0/0/0",
               bus.state_o, bus.score_o, bus.lives_o, bus.bombs_o, bus.invinc_o);
    end
    checks++;
    if ({bus.enemy_hit_o, bus.me_crash_o, bus.bomb_o} !== '0) begin
      errors++;
      $display("FAIL reset_pulses got %b exp 000000", {bus.enemy_hit_o, bus.me_crash_o, bus.bomb_o});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_hold state got %0d exp 0", bus.state_o); end
  endtask

  task automatic test_kill();
    act = 4'b1111;
    pixels(1, 0, 1, 4'b0100, 5);
    pixels(0, 0, 1, 4'b0010, 3);
    close_frame("kill_e2", 0, 0, 0, 4'b0000, 0);
    act = 4'b1011;
    pixels(1, 0, 1, 4'b0100, 4);
    close_frame("kill_edge_pixel", 1, 0, 1, 4'b1000, 0);
    act = 4'b1111;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checks++;
    if (bus.state_o !== 2'd1 || bus.score_o !== 16'(m_score)) begin
      errors++;
      $display("FAIL start_in_play state/score got %0d/%0d exp 1/%0d", bus.state_o, bus.score_o, m_score);
    end
  endtask

  task automatic test_crash_invinc();
    act = 4'b1111;
    pixels(1, 1, 0, 4'b0001, 3);
    close_frame("crash_first", 0, 0, 0, 4'b0000, 0);
    pixels(1, 1, 0, 4'b0001, 3);
    close_frame("crash_immune", 0, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 70 && m_inv > 0; i++)
      close_frame("invinc_count", 0, 0, 0, 4'b0000, 0);
  endtask

  task automatic test_bomb();
    int pulses;
    act = 4'b1011;
    pulses = 0;
    bus.bomb_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.bomb_o === 1'b1) pulses++;
    end
    bus.bomb_req_i = 1'b0;
    tick();
    m_bombs = m_bombs - 1; m_pend = 1;
    checks++;
    if (pulses !== 1 || bus.bombs_o !== 3'(m_bombs)) begin
      errors++;
      $display("FAIL bomb_held pulses/bombs got %0d/%0d exp 1/%0d", pulses, bus.bombs_o, m_bombs);
    end
    close_frame("bomb_commit", 0, 0, 0, 4'b0000, 0);
    close_frame("bomb_on_commit", 0, 0, 0, 4'b0000, 1);
    close_frame("bomb_next_frame", 0, 0, 0, 4'b0000, 0);
    pulses = 0;
    bus.bomb_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.bomb_o === 1'b1) pulses++;
    end
    bus.bomb_req_i = 1'b0;
    tick();
    checks++;
    if (pulses !== 0 || bus.bombs_o !== 3'd0) begin
      errors++;
      $display("FAIL bomb_empty pulses/bombs got %0d/%0d exp 0/0", pulses, bus.bombs_o);
    end
    close_frame("bomb_empty_commit", 0, 0, 0, 4'b0000, 0);
  endtask

  task automatic test_game_over();
    int pulses;
    act = 4'b1011;
    pixels(1, 1, 0, 4'b0100, 3);
    close_frame("crash_inactive", 0, 0, 0, 4'b0000, 0);
    act = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      pixels(1, 1, 0, 4'b0010, 2);
      close_frame("crash_spaced", 0, 0, 0, 4'b0000, 0);
      for (int i = 0; i < 70 && m_inv > 0 && m_state == 2'd1; i++)
        close_frame("crash_wait", 0, 0, 0, 4'b0000, 0);
    end
    pixels(1, 1, 1, 4'b1111, 3);
    close_frame("over_hold", 0, 0, 0, 4'b0000, 0);
    pulses = 0;
    bus.bomb_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.bomb_o === 1'b1) pulses++;
    end
    bus.bomb_req_i = 1'b0;
    tick();
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL over_bomb pulses got %0d exp 0", pulses); end
    start_game("restart");
  endtask

  task automatic test_saturate();
    logic [3:0] pat [5];
    int m;
    pat[0] = 4'b1111; pat[1] = 4'b1111; pat[2] = 4'b1111; pat[3] = 4'b0011; pat[4] = 4'b0111;
    sbus.enemy_active_i = 4'b1111;
    sbus.start_i = 1'b1;
    tick();
    sbus.start_i = 1'b0;
    m = 0;
    for (int f = 0; f < 5; f++) begin
      sbus.pixel_valid_i = 1'b1; sbus.bullet_alpha_i = 1'b1; sbus.enemy_alpha_i = pat[f];
      tick();
      sbus.pixel_valid_i = 1'b0; sbus.bullet_alpha_i = 1'b0; sbus.enemy_alpha_i = '0;
      sbus.frame_start_i = 1'b1;
      tick();
      sbus.frame_start_i = 1'b0;
      m = m + $countones(pat[f]);
      if (m > 15) m = 15;
      checks++;
      if (sbus.score_o !== 4'(m) || sbus.enemy_hit_o !== pat[f]) begin
        errors++;
        $display("FAIL sat_frame%0d score/hit got %0d/%b exp %0d/%b", f, sbus.score_o, sbus.enemy_hit_o, m, pat[f]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    act = 4'b1111;
    pixels(1, 0, 1, 4'b0001, 2);
    close_frame("pre_reset_kill", 0, 0, 0, 4'b0000, 0);
    bus.pixel_valid_i = 1'b1; bus.bullet_alpha_i = 1'b1; bus.me_alpha_i = 1'b1; bus.enemy_alpha_i = 4'b0110;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.state_o, bus.score_o, bus.lives_o, bus.bombs_o, bus.invinc_o,
         bus.enemy_hit_o, bus.me_crash_o, bus.bomb_o} !== '0) begin
      errors++;
      $display("FAIL async_reset state/score/lives/bombs got %0d/%0d/%0d/%0d exp 0/0/0/0",
               bus.state_o, bus.score_o, bus.lives_o, bus.bombs_o);
    end
    checks++;
    if (sbus.score_o !== 4'd0 || sbus.state_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_sat score/state got %0d/%0d exp 0/0", sbus.score_o, sbus.state_o);
    end
    clear_inputs();
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    start_game("start_after_reset");
    close_frame("discarded_frame", 0, 0, 0, 4'b0000, 0);
  endtask

  initial begin
    clear_inputs();
    sbus.pixel_valid_i = 1'b0; sbus.frame_start_i = 1'b0; sbus.me_alpha_i = 1'b0;
    sbus.bullet_alpha_i = 1'b0; sbus.enemy_alpha_i = '0; sbus.enemy_active_i = '0;
    sbus.start_i = 1'b0; sbus.bomb_req_i = 1'b0;
    act = 4'b0000;
    model_reset();
    test_reset();
    start_game("start");
    test_kill();
    test_crash_invinc();
    test_bomb();
    test_game_over();
    test_saturate();
    test_reset_midframe();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_collide_ctrl.md
Name: game_collide_ctrl

Overview:
Frame-based collision and game-state controller for the plane-war video pipeline. Sits after the sprite layer generators and samples per-pixel alpha of player, bullet and N enemy sprites during active scan. Accumulates overlaps across the frame and commits them once per frame at the vsync boundary. Maintains score, lives, bomb stock, post-hit invincibility and the IDLE/PLAY/OVER game FSM.

Parameters:
N_ENEMY, 4, number of enemy sprite channels (1..16)
SCORE_W, 16, score counter width; saturates at all-ones
LIVES_INIT, 3, lives loaded on game start (1..7)
BOMBS_INIT, 2, bombs loaded on game start (0..7)
INVINC_FRAMES, 60, frames of immunity after player hit (>=1)

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous reset, active-low
pixel_valid_i  in  1  active-video pixel strobe; alphas sampled only when high
frame_start_i  in  1  one-cycle pulse at frame boundary (vsync)
me_alpha_i  in  1  player sprite opaque at current pixel
bullet_alpha_i  in  1  any bullet opaque at current pixel
enemy_alpha_i  in  N_ENEMY  per-enemy opaque at current pixel
enemy_active_i  in  N_ENEMY  enemy slot currently alive
start_i  in  1  start/restart request (level)
bomb_req_i  in  1  bomb button, synchronised, level
state_o  out  2  0 IDLE, 1 PLAY, 2 OVER
enemy_hit_o  out  N_ENEMY  one-cycle per-enemy kill pulse at commit
me_crash_o  out  1  one-cycle pulse when a life is lost
bomb_o  out  1  one-cycle pulse when a bomb is fired
score_o  out  SCORE_W  current score
lives_o  out  3  remaining lives
bombs_o  out  3  remaining bombs
invinc_o  out  1  player currently immune

Behaviour:
- Reset (rst low, async): state IDLE; score 0; lives 0; bombs 0; invinc counter 0; all sticky flags and bomb_pending 0; all pulse outputs 0.
- IDLE/OVER: start_i high -> next cycle PLAY, lives=LIVES_INIT, bombs=BOMBS_INIT, score=0, flags cleared, invinc=0. Accumulation and bomb disabled outside PLAY; score/lives hold in OVER.
- Accumulate (PLAY, pixel_valid_i high): kill_flag[i] |= bullet_alpha_i & enemy_alpha_i[i]; crash_flag |= me_alpha_i & |(enemy_alpha_i & enemy_active_i).
- Bomb: rising edge of bomb_req_i in PLAY with bombs>0 -> bomb_o pulse next cycle, bombs-1, bomb_pending=1. bombs==0: ignored, no pulse. Held button fires once.
- Commit: cycle after frame_start_i sampled high (latency 1):
  - hit_vec = (kill_flag | {N{bomb_pending}}) & enemy_active_i; enemy_hit_o = hit_vec for exactly 1 cycle.
  - score += popcount(hit_vec), saturating at 2^SCORE_W-1.
  - crash_flag & invinc==0: me_crash_o pulse, lives-1, invinc=INVINC_FRAMES. Else invinc decrements if nonzero.
  - lives becomes 0 -> state OVER same commit edge.
  - All flags and bomb_pending cleared.
- Simultaneous: pixel_valid_i with frame_start_i -> pixel belongs to closing frame. Bomb edge on commit cycle -> pending for next commit. start_i in PLAY ignored.
- Reset mid-frame discards partial flags; no pulses emitted.

Decomposition:
- Shared package game_pkg: state encoding (ST_IDLE, ST_PLAY, ST_OVER), lives/bombs width 3, default constants.
- One sub-module: collide_accum (N_ENEMY sticky flags, clear on commit, popcount output), reusable for future bullet-vs-boss channels.

Test Plan:
- Reset then start_i 1 cycle -> state_o=1, lives_o=3, bombs_o=2, score_o=0.
- Frame with bullet overlapping enemy 2 (active) for 5 pixels -> after frame_start, enemy_hit_o=4'b0100 one cycle, score_o=1.
- Player overlaps enemy 0 two consecutive frames -> one me_crash_o, lives_o=2, invinc_o high 60 frames, second frame no loss.
- bomb_req_i held 10 cycles, enemies 0,1,3 active -> bomb_o once, bombs_o=1; commit enemy_hit_o=4'b1011, score +3; third press after bombs 0 -> no pulse.
- Three spaced crashes -> lives_o=0, state_o=2 on third commit; further overlaps no change; start_i restarts.
- score preloaded near max (SCORE_W=4, score 14) plus 3 kills -> score_o=15; async rst low mid-frame -> all outputs to reset values immediately.
